multicycle_ctrl: RTL
====================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have one clock, with a synchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 opcode  input  7  instruction[6:0] from the instruction register, valid from DECODE onward.
REQ-005 br_taken  input  1  branch comparison result from the ALU, valid in EXEC.
REQ-006 mem_ready  input  1  memory accepts or completes the current mem_req this cycle.
REQ-007 mem_req  output  1  memory transaction request.
REQ-008 mem_sel  output  1  address source: 0 = PC (instruction), 1 = ALU result (data).
REQ-009 mem_we  output  1  store request (data write).
REQ-010 ir_we  output  1  instruction register write enable.
REQ-011 pc_we  output  1  PC write enable.
REQ-012 pc_src  output  1  next PC: 0 = pc+4, 1 = old_pc+imm.
REQ-013 alu_a_sel  output  2  ALU A operand: 0 = rs1, 1 = old_pc, 2 = zero.
REQ-014 alu_b_sel  output  1  ALU B operand: 0 = rs2, 1 = immediate-generator output.
REQ-015 rf_we  output  1  register file write enable.
REQ-016 wb_sel  output  2  writeback source: 0 = ALU, 1 = memory data, 2 = pc+4.
REQ-017 retire  output  1  one-cycle pulse when an instruction completes.
REQ-018 state  output  3  current state, for debug.
REQ-019 illegal  output  1  sticky illegal-opcode flag (see Configuration).

Function
REQ-020 States and encodings SHALL be FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4, TRAP = 5.
REQ-021 Legal opcodes SHALL be the following instruction classes:
- R (0110011)
- I (0010011)
- LOAD (0000011)
- STORE (0100011)
- BRANCH (1100011)
- LUI (0110111)
- AUIPC (0010111)
- JAL (1101111)
REQ-022 In DECODE, the block SHALL latch the opcode into an internal class register; later states SHALL use only that register, never the live opcode.
REQ-023 FETCH behaviour:
- mem_req = 1 and mem_sel = 0 while in FETCH.
- Stay in FETCH while mem_ready = 0.
- When mem_ready = 1: ir_we = 1, pc_we = 1, pc_src = 0 in that same cycle (Mealy), then go to DECODE.
REQ-024 DECODE SHALL last exactly one cycle, then go to EXEC for a legal opcode.
REQ-025 EXEC behaviour by class:
- R: alu_a_sel = 0, alu_b_sel = 0, then WB.
- I, LOAD, STORE: alu_a_sel = 0, alu_b_sel = 1; I goes to WB, LOAD and STORE go to MEM.
- LUI: alu_a_sel = 2, alu_b_sel = 1, then WB.
- AUIPC: alu_a_sel = 1, alu_b_sel = 1, then WB.
- BRANCH: pc_src = 1, pc_we = br_taken, retire = 1, then FETCH.
- JAL: pc_src = 1, pc_we = 1, then WB.
REQ-026 MEM behaviour:
- mem_req = 1 and mem_sel = 1; mem_we = 1 for STORE only.
- Hold all three outputs stable while mem_ready = 0.
- On mem_ready = 1: LOAD goes to WB; STORE asserts retire and goes to FETCH.
REQ-027 WB SHALL assert rf_we = 1 and retire = 1 for exactly one cycle, then go to FETCH. wb_sel = 1 for LOAD, 2 for JAL, 0 otherwise.
REQ-028 Any output not explicitly driven in a state SHALL be 0.
REQ-029 mem_req SHALL drop in the cycle after mem_ready is sampled high; exactly one transaction is made per request.
REQ-030 Latency with mem_ready tied high SHALL be:
- R, I, LUI, AUIPC, JAL: 4 cycles.
- LOAD: 5 cycles.
- STORE: 4 cycles.
- BRANCH: 3 cycles.
REQ-031 The state register SHALL be the only state in the block besides the class register and the illegal flag.

Reset
REQ-032 When rst_n = 0 at a clock edge, the next state SHALL be FETCH and illegal SHALL be cleared, regardless of the current state. This includes reset mid-MEM or mid-TRAP; a pending mem_req is abandoned.
REQ-033 While in reset, and in the first FETCH cycle after it, every output except mem_req SHALL be 0; state = 0 and mem_req = 1 from the first post-reset cycle.

Configuration
REQ-034 The macro MC_ILLEGAL_TRAP_EN SHALL control illegal-opcode handling.
REQ-035 With MC_ILLEGAL_TRAP_EN defined:
- An illegal opcode in DECODE goes to TRAP.
- TRAP sets illegal = 1 and drives every other output to 0.
- TRAP is left only by reset.
REQ-036 With MC_ILLEGAL_TRAP_EN undefined:
- An illegal opcode in DECODE asserts retire and goes to FETCH (NOP behaviour).
- illegal is tied to 0 and TRAP is unreachable.

Verification
REQ-037 Reset, then opcode 0110011 with mem_ready = 1 -> states 0,1,2,4,0; rf_we and retire high only in WB; wb_sel = 0.
REQ-038 LOAD with mem_ready held low for 3 MEM cycles -> mem_req = 1, mem_sel = 1, mem_we = 0 held for 4 cycles; then WB with wb_sel = 1; total latency 8 cycles.
REQ-039 Run BRANCH twice:
- br_taken = 1 -> pc_we = 1 and pc_src = 1 in EXEC.
- br_taken = 0 -> pc_we = 0 in EXEC.
- Both cases: retire in EXEC, back to FETCH after 3 cycles.
REQ-040 Opcode 1100111 -> with the macro: state 5, illegal = 1 held for 10 cycles until rst_n = 0. Without the macro: retire pulse in DECODE, then FETCH.
REQ-041 rst_n = 0 for one cycle during MEM of a STORE -> next state 0, mem_we = 0 immediately, no retire pulse.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control FSM for a multicycle RV32-style datapath.
// Sequences FETCH -> DECODE -> EXEC -> (MEM) -> (WB) and drives the datapath
// selects and write enables. Opcode class is captured in DECODE so later
// states are immune to changes on the live opcode bus.
// Optional feature: define MC_ILLEGAL_TRAP_EN to lock up in TRAP on an
// illegal opcode. By default an illegal opcode retires as a NOP.
module multicycle_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       br_taken,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_sel,
  output logic       mem_we,
  output logic       ir_we,
  output logic       pc_we,
  output logic       pc_src,
  output logic [1:0] alu_a_sel,
  output logic       alu_b_sel,
  output logic       rf_we,
  output logic [1:0] wb_sel,
  output logic       retire,
  output logic [2:0] state,
  output logic       illegal
);

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    CL_R      = 4'd0,
    CL_I      = 4'd1,
    CL_LOAD   = 4'd2,
    CL_STORE  = 4'd3,
    CL_BRANCH = 4'd4,
    CL_LUI    = 4'd5,
    CL_AUIPC  = 4'd6,
    CL_JAL    = 4'd7,
    CL_ILL    = 4'd8
  } class_t;

  // Map a raw opcode onto an instruction class; anything unknown is illegal.
  function automatic class_t decode_class(input logic [6:0] op);
    case (op)
      7'b0110011: decode_class = CL_R;
      7'b0010011: decode_class = CL_I;
      7'b0000011: decode_class = CL_LOAD;
      7'b0100011: decode_class = CL_STORE;
      7'b1100011: decode_class = CL_BRANCH;
      7'b0110111: decode_class = CL_LUI;
      7'b0010111: decode_class = CL_AUIPC;
      7'b1101111: decode_class = CL_JAL;
      default:    decode_class = CL_ILL;
    endcase
  endfunction

  state_t     state_r;
  state_t     next_state_s;
  class_t     class_r;
  class_t     class_dec_s;
  logic       mem_req_s;
  logic       mem_sel_s;
  logic       mem_we_s;
  logic       ir_we_s;
  logic       pc_we_s;
  logic       pc_src_s;
  logic [1:0] alu_a_sel_s;
  logic       alu_b_sel_s;
  logic       rf_we_s;
  logic [1:0] wb_sel_s;
  logic       retire_s;
  logic       illegal_s;

  assign class_dec_s = decode_class(opcode);
  assign state       = state_r;

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Class register: captured only in DECODE, held everywhere else.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      class_r <= CL_ILL;
    end else if (state_r == ST_DECODE) begin
      class_r <= class_dec_s;
    end else begin
      class_r <= class_r;
    end
  end

`ifdef MC_ILLEGAL_TRAP_EN
  logic illegal_r;

  // Sticky illegal flag, set on entry to TRAP and cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      illegal_r <= 1'b0;
    end else if (next_state_s == ST_TRAP) begin
      illegal_r <= 1'b1;
    end else begin
      illegal_r <= illegal_r;
    end
  end

  assign illegal_s = illegal_r;
`else
  assign illegal_s = 1'b0;
`endif

  // Next-state and raw control outputs; everything defaults to 0.
  always_comb begin
    next_state_s = state_r;
    mem_req_s    = 1'b0;
    mem_sel_s    = 1'b0;
    mem_we_s     = 1'b0;
    ir_we_s      = 1'b0;
    pc_we_s      = 1'b0;
    pc_src_s     = 1'b0;
    alu_a_sel_s  = 2'd0;
    alu_b_sel_s  = 1'b0;
    rf_we_s      = 1'b0;
    wb_sel_s     = 2'd0;
    retire_s     = 1'b0;
    case (state_r)
      ST_FETCH: begin
        mem_req_s = 1'b1;
        if (mem_ready) begin
          ir_we_s      = 1'b1;
          pc_we_s      = 1'b1;
          next_state_s = ST_DECODE;
        end else begin
          next_state_s = ST_FETCH;
        end
      end
      ST_DECODE: begin
        if (class_dec_s == CL_ILL) begin
`ifdef MC_ILLEGAL_TRAP_EN
          next_state_s = ST_TRAP;
`else
          retire_s     = 1'b1;
          next_state_s = ST_FETCH;
`endif
        end else begin
          next_state_s = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (class_r)
          CL_R: next_state_s = ST_WB;
          CL_I: begin
            alu_b_sel_s  = 1'b1;
            next_state_s = ST_WB;
          end
          CL_LOAD, CL_STORE: begin
            alu_b_sel_s  = 1'b1;
            next_state_s = ST_MEM;
          end
          CL_LUI: begin
            alu_a_sel_s  = 2'd2;
            alu_b_sel_s  = 1'b1;
            next_state_s = ST_WB;
          end
          CL_AUIPC: begin
            alu_a_sel_s  = 2'd1;
            alu_b_sel_s  = 1'b1;
            next_state_s = ST_WB;
          end
          CL_BRANCH: begin
            pc_src_s     = 1'b1;
            pc_we_s      = br_taken;
            retire_s     = 1'b1;
            next_state_s = ST_FETCH;
          end
          CL_JAL: begin
            pc_src_s     = 1'b1;
            pc_we_s      = 1'b1;
            next_state_s = ST_WB;
          end
          default: next_state_s = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        mem_req_s = 1'b1;
        mem_sel_s = 1'b1;
        mem_we_s  = (class_r == CL_STORE);
        if (mem_ready) begin
          if (class_r == CL_STORE) begin
            retire_s     = 1'b1;
            next_state_s = ST_FETCH;
          end else begin
            next_state_s = ST_WB;
          end
        end else begin
          next_state_s = ST_MEM;
        end
      end
      ST_WB: begin
        rf_we_s      = 1'b1;
        retire_s     = 1'b1;
        next_state_s = ST_FETCH;
        if (class_r == CL_LOAD) begin
          wb_sel_s = 2'd1;
        end else if (class_r == CL_JAL) begin
          wb_sel_s = 2'd2;
        end else begin
          wb_sel_s = 2'd0;
        end
      end
      ST_TRAP: begin
`ifdef MC_ILLEGAL_TRAP_EN
        next_state_s = ST_TRAP;
`else
        next_state_s = ST_FETCH;
`endif
      end
      default: next_state_s = ST_FETCH;
    endcase
  end

  // Output stage: everything is forced low while reset is asserted so an
  // in-flight memory request or retire is abandoned immediately.
  always_comb begin
    if (!rst_n) begin
      mem_req   = 1'b0;
      mem_sel   = 1'b0;
      mem_we    = 1'b0;
      ir_we     = 1'b0;
      pc_we     = 1'b0;
      pc_src    = 1'b0;
      alu_a_sel = 2'd0;
      alu_b_sel = 1'b0;
      rf_we     = 1'b0;
      wb_sel    = 2'd0;
      retire    = 1'b0;
      illegal   = 1'b0;
    end else begin
      mem_req   = mem_req_s;
      mem_sel   = mem_sel_s;
      mem_we    = mem_we_s;
      ir_we     = ir_we_s;
      pc_we     = pc_we_s;
      pc_src    = pc_src_s;
      alu_a_sel = alu_a_sel_s;
      alu_b_sel = alu_b_sel_s;
      rf_we     = rf_we_s;
      wb_sel    = wb_sel_s;
      retire    = retire_s;
      illegal   = illegal_s;
    end
  end

endmodule
